sd_acq_seq_ctrl: RTL and testbench

Sequencer for the echo-acquisition path. It generates the acquisition gate that drives the acquisition timer's enable. The timer counter clears whenever the gate is low and counts dds ticks while it is high. The block runs a CPMG-style train of N echo periods, each with a dead time, an acquisition window and a gap. It is clocked by dds and sits between the pulse-sequence state machine (start/abort) and the acquisition timer/ADC capture logic.

---
 rtl/sd_acq_seq_ctrl_if.sv | 39 +++
 rtl/sd_acq_seq_ctrl.sv | 153 +++++++++++++++
 tb/tb_sd_acq_seq_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/sd_acq_seq_ctrl_if.sv
// Control/status bundle between the pulse-sequence FSM and the echo-acquisition sequencer.
// ACQ_SEQ_PHASE_ALT_EN adds the phase_sel receiver phase-cycling output.
interface sd_acq_seq_ctrl_if #(
    parameter int unsigned CW = 22,
    parameter int unsigned NW = 10
);
    logic          start;
    logic          abort;
    logic [CW-1:0] cfg_dead;
    logic [CW-1:0] cfg_win;
    logic [CW-1:0] cfg_period;
    logic [NW-1:0] cfg_necho;
    logic          busy;
    logic          acq_gate;
    logic          win_start;
    logic          win_end;
    logic [NW-1:0] echo_idx;
    logic          done;
    logic          cfg_err;
`ifdef ACQ_SEQ_PHASE_ALT_EN
    logic          phase_sel;
`endif

    modport master (
        output start, abort, cfg_dead, cfg_win, cfg_period, cfg_necho,
        input  busy, acq_gate, win_start, win_end, echo_idx, done, cfg_err
`ifdef ACQ_SEQ_PHASE_ALT_EN
        , input phase_sel
`endif
    );

    modport slave (
        input  start, abort, cfg_dead, cfg_win, cfg_period, cfg_necho,
        output busy, acq_gate, win_start, win_end, echo_idx, done, cfg_err
`ifdef ACQ_SEQ_PHASE_ALT_EN
        , output phase_sel
`endif
    );
endinterface

// File: rtl/sd_acq_seq_ctrl.sv
// CPMG-style echo acquisition sequencer: N periods of dead time, acquisition window and gap.
// Optional ACQ_SEQ_PHASE_ALT_EN adds phase_sel = echo_idx[0] during a run.
module sd_acq_seq_ctrl #(
    parameter int unsigned CW = 22,
    parameter int unsigned NW = 10
) (
    input logic              dds,
    input logic              rst_n,
    sd_acq_seq_ctrl_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StDead, StAcq, StGap, StDone} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [CW-1:0] dead_q, dead_d;
    logic [CW-1:0] win_q, win_d;
    logic [CW-1:0] period_q, period_d;
    logic [NW-1:0] necho_q, necho_d;
    logic [NW-1:0] echo_q, echo_d;
    logic          start_ok, cfg_bad;

    logic busy_q, busy_d, gate_q, gate_d, ws_q, ws_d, we_q, we_d;
    logic done_q, done_d, err_q, err_d;

    // Segment of the echo period that a given cycle offset falls into.
    function automatic state_e seg_state(input logic [CW-1:0] cyc, input logic [CW-1:0] dead,
                                         input logic [CW-1:0] win);
        logic [CW:0] acq_end;
        acq_end = {1'b0, dead} + {1'b0, win};
        if (cyc < dead) return StDead;
        else if ({1'b0, cyc} < acq_end) return StAcq;
        else return StGap;
    endfunction

    assign cfg_bad = (bus.cfg_win == '0) || (bus.cfg_necho == '0) ||
                     (({1'b0, bus.cfg_dead} + {1'b0, bus.cfg_win}) > {1'b0, bus.cfg_period});
    assign start_ok = (state_q == StIdle) && bus.start && !bus.abort;

    always_ff @(posedge dds or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cyc_q    <= '0;
            dead_q   <= '0;
            win_q    <= '0;
            period_q <= '0;
            necho_q  <= '0;
            echo_q   <= '0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            dead_q   <= dead_d;
            win_q    <= win_d;
            period_q <= period_d;
            necho_q  <= necho_d;
            echo_q   <= echo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        dead_d   = dead_q;
        win_d    = win_q;
        period_d = period_q;
        necho_d  = necho_q;
        echo_d   = echo_q;
        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    dead_d   = bus.cfg_dead;
                    win_d    = bus.cfg_win;
                    period_d = bus.cfg_period;
                    necho_d  = bus.cfg_necho;
                    echo_d   = '0;
                    cyc_d    = '0;
                    if (!cfg_bad) state_d = seg_state('0, bus.cfg_dead, bus.cfg_win);
                end
            end
            StDead, StAcq, StGap: begin
                if (bus.abort) begin
                    state_d = StIdle;
                    cyc_d   = '0;
                    echo_d  = '0;
                end else if (cyc_q == period_q - CW'(1)) begin
                    cyc_d = '0;
                    if (echo_q == necho_q - NW'(1)) begin
                        state_d = StDone;
                    end else begin
                        echo_d  = echo_q + NW'(1);
                        state_d = seg_state('0, dead_q, win_q);
                    end
                end else begin
                    cyc_d   = cyc_q + CW'(1);
                    state_d = seg_state(cyc_q + CW'(1), dead_q, win_q);
                end
            end
            StDone: begin
                state_d = StIdle;
                if (bus.abort) echo_d = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so that the registered copies line up with it.
    always_comb begin
        busy_d = (state_d == StDead) || (state_d == StAcq) || (state_d == StGap);
        gate_d = (state_d == StAcq);
        ws_d   = gate_d && (cyc_d == dead_d);
        we_d   = gate_d && (({1'b0, cyc_d} + (CW+1)'(1)) == ({1'b0, dead_d} + {1'b0, win_d}));
        done_d = (state_d == StDone);
        err_d  = start_ok && cfg_bad;
    end

    always_ff @(posedge dds or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            gate_q <= 1'b0;
            ws_q   <= 1'b0;
            we_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            gate_q <= gate_d;
            ws_q   <= ws_d;
            we_q   <= we_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.acq_gate  = gate_q;
    assign bus.win_start = ws_q;
    assign bus.win_end   = we_q;
    assign bus.echo_idx  = echo_q;
    assign bus.done      = done_q;
    assign bus.cfg_err   = err_q;

`ifdef ACQ_SEQ_PHASE_ALT_EN
    logic phase_q;

    always_ff @(posedge dds or negedge rst_n) begin
        if (!rst_n) phase_q <= 1'b0;
        else        phase_q <= busy_d && echo_d[0];
    end

    assign bus.phase_sel = phase_q;
`endif

endmodule

// File: tb/tb_sd_acq_seq_ctrl.sv
// Bench for sd_acq_seq_ctrl: directed scenarios plus random runs against a period-arithmetic model.
module tb_sd_acq_seq_ctrl;
    localparam int unsigned CW = 22;
    localparam int unsigned NW = 10;

    logic dds = 1'b0;
    logic rst_n = 1'b0;
    always #5 dds = ~dds;

    sd_acq_seq_ctrl_if #(.CW(CW), .NW(NW)) bus ();

    sd_acq_seq_ctrl #(.CW(CW), .NW(NW)) dut (
        .dds   (dds),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: phase 0 idle, 1 running (t = cycles since accepted start), 2 done cycle.
    int m_phase = 0;
    int m_t = 0;
    int m_dead = 0, m_win = 0, m_per = 0, m_nech = 0;
    int m_echo = 0;
    bit m_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_t     = 0;
        m_echo  = 0;
        m_err   = 1'b0;
    endtask

    task automatic model_step(input bit st, input bit ab, input int dead, input int win,
                              input int per, input int nech);
        m_err = 1'b0;
        case (m_phase)
            0: begin
                if (st && !ab) begin
                    m_echo = 0;
                    m_dead = dead;
                    m_win  = win;
                    m_per  = per;
                    m_nech = nech;
                    if (win == 0 || nech == 0 || dead + win > per) m_err = 1'b1;
                    else begin
                        m_phase = 1;
                        m_t     = 0;
                    end
                end
            end
            1: begin
                if (ab) begin
                    m_phase = 0;
                    m_echo  = 0;
                end else begin
                    m_t++;
                    if (m_t == m_nech * m_per) m_phase = 2;
                end
            end
            default: begin
                m_phase = 0;
                if (ab) m_echo = 0;
            end
        endcase
    endtask

    task automatic check_outputs();
        bit run;
        int c;
        run = (m_phase == 1);
        c   = 0;
        if (run) begin
            c      = m_t % m_per;
            m_echo = m_t / m_per;
        end
        check("busy", 32'(bus.busy), 32'(run));
        check("acq_gate", 32'(bus.acq_gate), 32'(run && c >= m_dead && c < m_dead + m_win));
        check("win_start", 32'(bus.win_start), 32'(run && c == m_dead));
        check("win_end", 32'(bus.win_end), 32'(run && c == m_dead + m_win - 1));
        check("echo_idx", 32'(bus.echo_idx), 32'(m_echo));
        check("done", 32'(bus.done), 32'(m_phase == 2));
        check("cfg_err", 32'(bus.cfg_err), 32'(m_err));
`ifdef ACQ_SEQ_PHASE_ALT_EN
        check("phase_sel", 32'(bus.phase_sel), 32'(run && (m_echo % 2 == 1)));
`endif
    endtask

    task automatic cycle(input bit st, input bit ab, input int dead, input int win, input int per,
                         input int nech);
        @(negedge dds);
        bus.start      = st;
        bus.abort      = ab;
        bus.cfg_dead   = CW'(dead);
        bus.cfg_win    = CW'(win);
        bus.cfg_period = CW'(per);
        bus.cfg_necho  = NW'(nech);
        model_step(st, ab, dead, win, per, nech);
        @(posedge dds);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, 0, 0, 0);
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.cfg_dead   = '0;
        bus.cfg_win    = '0;
        bus.cfg_period = '0;
        bus.cfg_necho  = '0;
        model_reset();
        repeat (2) @(posedge dds);
        @(negedge dds);
        check_outputs();
        rst_n = 1'b1;

        // Nominal run, then boundary configs.
        cycle(1'b1, 1'b0, 3, 5, 12, 2);
        idle(27);
        cycle(1'b1, 1'b0, 0, 4, 4, 3);
        idle(15);
        cycle(1'b1, 1'b0, 2, 1, 4, 3);
        idle(15);

        // Rejected configurations.
        cycle(1'b1, 1'b0, 8, 5, 12, 2);
        idle(2);
        cycle(1'b1, 1'b0, 3, 5, 12, 0);
        idle(2);
        cycle(1'b1, 1'b0, 3, 0, 12, 2);
        idle(2);

        // Abort in second window; abort with start in idle.
        cycle(1'b1, 1'b0, 3, 5, 12, 2);
        idle(16);
        cycle(1'b0, 1'b1, 0, 0, 0, 0);
        idle(3);
        cycle(1'b1, 1'b1, 3, 5, 12, 2);
        idle(3);

        // Config change and start mid-run must be ignored.
        cycle(1'b1, 1'b0, 3, 5, 12, 2);
        idle(5);
        cycle(1'b1, 1'b0, 0, 1, 2, 7);
        idle(22);

        // Async reset during ACQ.
        cycle(1'b1, 1'b0, 3, 5, 12, 2);
        idle(4);
        @(negedge dds);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge dds);
        rst_n = 1'b1;
        idle(2);

`ifdef ACQ_SEQ_PHASE_ALT_EN
        cycle(1'b1, 1'b0, 3, 5, 12, 4);
        idle(52);
`endif

        // Random runs with occasional invalid configs, mid-run starts and aborts.
        for (int i = 0; i < 3000; i++) begin
            bit st, ab;
            int dead, win, per, nech;
            dead = int'($urandom_range(0, 4));
            win  = int'($urandom_range(0, 5));
            per  = int'($urandom_range(1, 14));
            nech = int'($urandom_range(0, 4));
            st   = ($urandom_range(0, 3) == 0);
            ab   = (m_phase == 0) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 79) == 0);
            cycle(st, ab, dead, win, per, nech);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
